// File: rtl/if_prefetch_stage_pkg.sv
// Shared types for the instruction prefetch stage.
//   NOP          : canonical RISC-V nop (addi x0,x0,0)
//   redir_e      : which redirect source won arbitration this cycle
//   fq_entry_t   : fetch-queue payload {word pc, instruction} = 62 bits
//   redir_pick() : fixed-priority redirect arbitration
package if_prefetch_stage_pkg;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    RD_NONE,
    RD_START,
    RD_ECALL,
    RD_JMP,
    RD_FLUSH
  } redir_e;

  typedef struct packed {
    logic [29:0] pc;
    logic [31:0] inst;
  } fq_entry_t;

  localparam int FQ_W = $bits(fq_entry_t);

  // Monitor start beats a trap, a trap beats a branch, and a branch beats a
  // replay flush; only the winner is allowed to act.
  function automatic redir_e redir_pick(input logic start, input logic ecall,
                                        input logic jmp, input logic flush);
    if (start)      return RD_START;
    else if (ecall) return RD_ECALL;
    else if (jmp)   return RD_JMP;
    else if (flush) return RD_FLUSH;
    else            return RD_NONE;
  endfunction

endpackage

// File: rtl/if_fetch_fifo.sv
// Fetch queue: a small circular FIFO with a synchronous flush.
//   clk, rst_n   : clock, async active-low reset
//   flush        : drop all entries (wins over push/pop)
//   push / din   : write an entry; ignored when full
//   pop          : retire the head; ignored when empty
//   dout         : head entry, zero while empty
//   empty, count : occupancy
module if_fetch_fifo #(
  parameter int W     = 62,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign do_push = push & (count != FULL_CNT);
  assign do_pop  = pop & ~empty;
  assign dout    = empty ? '0 : mem[rptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wptr] <= din;
  end

endmodule

// File: rtl/inst_1r1w.sv
// Instruction RAM, one synchronous read port and one write port.
//   clk          : clock
//   radr / rdata : read address, data registered one cycle after radr
//   wadr / wdata / wen : write port
// A read and a write to the same address in one cycle return the old word.
// Contents are not reset.
module inst_1r1w #(
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic [AW-1:0] radr,
  output logic [31:0]   rdata,
  input  logic [AW-1:0] wadr,
  input  logic [31:0]   wdata,
  input  logic          wen
);

  logic [31:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (wen) mem[wadr] <= wdata;
    rdata <= mem[radr];
  end

endmodule

// File: rtl/if_prefetch_stage.sv
// Instruction-fetch prefetch stage: streams sequential words out of the
// instruction RAM into a fetch queue feeding ID, and redirects on start,
// trap, branch or replay flush. The monitor can steal the RAM read port.
//   clk, rst_n                        : clock, async active-low reset
//   inst_id / pc_id / valid_id        : queue head to ID
//   ready_id                          : ID accepts the head
//   jmp_condition_ex / jmp_adr_ex     : branch/jump redirect
//   ecall_condition_ex / csr_mtvec_ex : trap redirect
//   cpu_start / start_adr             : monitor start
//   rst_pipe                          : flush and replay from the head pc
//   i_ram_radr / i_ram_rdata          : monitor read port (i_read_sel=1)
//   i_ram_wadr / i_ram_wdata / i_ram_wen : monitor write port
//   pc_data                           : byte address of the next fetch
module if_prefetch_stage
  import if_prefetch_stage_pkg::*;
#(
  parameter int          IRAM_AW  = 12,
  parameter int          FQ_DEPTH = 4,
  parameter logic [29:0] RESET_PC = 30'd0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [31:0]        inst_id,
  output logic [29:0]        pc_id,
  output logic               valid_id,
  input  logic               ready_id,
  input  logic               jmp_condition_ex,
  input  logic [29:0]        jmp_adr_ex,
  input  logic               ecall_condition_ex,
  input  logic [29:0]        csr_mtvec_ex,
  input  logic               cpu_start,
  input  logic [29:0]        start_adr,
  input  logic               rst_pipe,
  input  logic [IRAM_AW-1:0] i_ram_radr,
  output logic [31:0]        i_ram_rdata,
  input  logic [IRAM_AW-1:0] i_ram_wadr,
  input  logic [31:0]        i_ram_wdata,
  input  logic               i_ram_wen,
  input  logic               i_read_sel,
  output logic [31:0]        pc_data
);

  localparam int CW = $clog2(FQ_DEPTH) + 1;

  logic [29:0]        pc_if, inflight_pc;
  logic               inflight;
  logic [CW-1:0]      count;
  logic               empty, redirect, issue, push, pop;
  logic [IRAM_AW-1:0] ram_radr;
  logic [31:0]        ram_rdata;
  redir_e             cause;
  fq_entry_t          head, ret;

  assign cause    = redir_pick(cpu_start, ecall_condition_ex, jmp_condition_ex, rst_pipe);
  assign redirect = (cause != RD_NONE);

  // Count the outstanding RAM read as occupied so its return always has a slot.
  assign issue = !i_read_sel && !redirect &&
                 (({1'b0, count} + (CW+1)'(inflight)) < (CW+1)'(FQ_DEPTH));

  // pc_if is a word address, so its low bits are the RAM word index.
  assign ram_radr = i_read_sel ? i_ram_radr : pc_if[IRAM_AW-1:0];

  // A return arriving in a redirect cycle belongs to the old path.
  assign push     = inflight & ~redirect;
  assign ret.pc   = inflight_pc;
  assign ret.inst = ram_rdata;
  assign pop      = valid_id & ready_id;

  inst_1r1w #(.AW(IRAM_AW)) u_ram (
    .clk   (clk),
    .radr  (ram_radr),
    .rdata (ram_rdata),
    .wadr  (i_ram_wadr),
    .wdata (i_ram_wdata),
    .wen   (i_ram_wen)
  );

  if_fetch_fifo #(.W(FQ_W), .DEPTH(FQ_DEPTH)) u_fq (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (redirect),
    .push  (push),
    .din   (ret),
    .pop   (pop),
    .dout  (head),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_if       <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else begin
      inflight    <= issue;
      inflight_pc <= pc_if;
      case (cause)
        RD_START: pc_if <= start_adr;
        RD_ECALL: pc_if <= csr_mtvec_ex;
        RD_JMP:   pc_if <= jmp_adr_ex;
        // Replay from the oldest unretired instruction; nothing queued means
        // pc_if already points at the next one to fetch.
        RD_FLUSH: if (!empty) pc_if <= head.pc;
        default:  if (issue) pc_if <= pc_if + 30'd1;
      endcase
    end
  end

  assign valid_id    = ~empty;
  assign inst_id     = head.inst;
  assign pc_id       = head.pc;
  assign i_ram_rdata = ram_rdata;
  assign pc_data     = {pc_if, 2'b00};

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Directed bench for if_prefetch_stage. RAM is preloaded with word a = a+1,
// so every expected instruction is its pc's low 12 bits plus one.
module tb_if_prefetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] inst_id;
  logic [29:0] pc_id;
  logic        valid_id;
  logic        ready_id;
  logic        jmp_condition_ex;
  logic [29:0] jmp_adr_ex;
  logic        ecall_condition_ex;
  logic [29:0] csr_mtvec_ex;
  logic        cpu_start;
  logic [29:0] start_adr;
  logic        rst_pipe;
  logic [11:0] i_ram_radr;
  logic [31:0] i_ram_rdata;
  logic [11:0] i_ram_wadr;
  logic [31:0] i_ram_wdata;
  logic        i_ram_wen;
  logic        i_read_sel;
  logic [31:0] pc_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  if_prefetch_stage dut (
    .clk(clk), .rst_n(rst_n),
    .inst_id(inst_id), .pc_id(pc_id), .valid_id(valid_id), .ready_id(ready_id),
    .jmp_condition_ex(jmp_condition_ex), .jmp_adr_ex(jmp_adr_ex),
    .ecall_condition_ex(ecall_condition_ex), .csr_mtvec_ex(csr_mtvec_ex),
    .cpu_start(cpu_start), .start_adr(start_adr), .rst_pipe(rst_pipe),
    .i_ram_radr(i_ram_radr), .i_ram_rdata(i_ram_rdata),
    .i_ram_wadr(i_ram_wadr), .i_ram_wdata(i_ram_wdata), .i_ram_wen(i_ram_wen),
    .i_read_sel(i_read_sel), .pc_data(pc_data)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_head(input string tag, input logic [29:0] pc);
    logic [31:0] e;
    e = {20'd0, pc[11:0]} + 32'd1;
    chk({tag, "_valid"}, valid_id, 1);
    chk({tag, "_pc"}, pc_id, pc);
    chk({tag, "_inst"}, inst_id, e);
  endtask

  // advance one clock and land on the sampling edge
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic redir_settle();
    jmp_condition_ex = 0; ecall_condition_ex = 0; cpu_start = 0; rst_pipe = 0;
  endtask

  initial begin
    rst_n = 0; ready_id = 0; i_read_sel = 1; i_ram_wen = 0;
    i_ram_radr = '0; i_ram_wadr = '0; i_ram_wdata = '0;
    jmp_condition_ex = 0; jmp_adr_ex = '0; ecall_condition_ex = 0; csr_mtvec_ex = '0;
    cpu_start = 0; start_adr = '0; rst_pipe = 0;

    for (int a = 0; a < 4096; a++) begin
      @(negedge clk);
      i_ram_wen = 1; i_ram_wadr = a[11:0]; i_ram_wdata = 32'(a + 1);
    end
    @(negedge clk);
    i_ram_wen = 0; i_read_sel = 0; ready_id = 1;

    chk("rst_valid", valid_id, 0);
    chk("rst_inst", inst_id, 0);
    chk("rst_pc_id", pc_id, 0);
    chk("rst_pc_data", pc_data, 0);

    // streaming from reset
    rst_n = 1;
    step();
    chk("t1_c1_valid", valid_id, 0);
    for (int k = 0; k < 6; k++) begin
      step();
      chk_head("t1_seq", 30'(k));
    end

    // stall from reset: queue fills to depth, pc_if stops at 4
    rst_n = 0; ready_id = 0;
    step();
    rst_n = 1;
    repeat (10) step();
    chk("t2_pc_data", pc_data, 32'd16);
    chk_head("t2_hold", 30'd0);
    ready_id = 1;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk_head("t2_drain", 30'(k));
    end

    // jump with entries queued and a read in flight
    ready_id = 0;
    step();
    jmp_condition_ex = 1; jmp_adr_ex = 30'h40; ready_id = 1;
    step();
    redir_settle();
    chk("t3_flush_valid", valid_id, 0);
    chk("t3_pc_data", pc_data, 32'h100);
    step();
    chk("t3_stale_valid", valid_id, 0);
    step();
    chk_head("t3_tgt", 30'h40);
    step();
    chk_head("t3_next", 30'h41);

    // ecall beats jmp
    ecall_condition_ex = 1; csr_mtvec_ex = 30'h100;
    jmp_condition_ex = 1; jmp_adr_ex = 30'h40;
    step();
    redir_settle();
    step();
    step();
    chk_head("t4_ecall", 30'h100);
    step();
    chk_head("t4_ecall_next", 30'h101);

    // cpu_start beats ecall
    cpu_start = 1; start_adr = 30'h20; ecall_condition_ex = 1;
    step();
    redir_settle();
    step();
    step();
    chk_head("t4_start", 30'h20);

    // replay flush with head pc 5
    jmp_condition_ex = 1; jmp_adr_ex = 30'd5;
    step();
    redir_settle();
    step();
    step();
    chk_head("t5_pre", 30'd5);
    ready_id = 0;
    step();
    chk_head("t5_held", 30'd5);
    rst_pipe = 1;
    step();
    redir_settle();
    ready_id = 1;
    chk("t5_flush_valid", valid_id, 0);
    chk("t5_pc_data", pc_data, 32'd20);
    step();
    chk("t5_gap_valid", valid_id, 0);
    step();
    chk_head("t5_replay", 30'd5);

    // monitor steals the read port mid-run
    ready_id = 0; i_read_sel = 1; i_ram_radr = 12'd3;
    step();
    chk("t6_rdata3", i_ram_rdata, 32'd4);
    chk("t6_pc_data", pc_data, 32'd28);
    chk_head("t6_keep", 30'd5);
    i_ram_radr = 12'h10;
    step();
    chk("t6_rdata10", i_ram_rdata, 32'h11);
    chk("t6_pc_data2", pc_data, 32'd28);
    i_read_sel = 0; ready_id = 1;
    for (int k = 6; k <= 9; k++) begin
      step();
      chk_head("t6_resume", 30'(k));
    end

    // same-address read and write returns old data
    ready_id = 0; i_read_sel = 1; i_ram_radr = 12'd3;
    i_ram_wen = 1; i_ram_wadr = 12'd3; i_ram_wdata = 32'hDEAD;
    step();
    chk("t7_old", i_ram_rdata, 32'd4);
    i_ram_wen = 0;
    step();
    chk("t7_new", i_ram_rdata, 32'hDEAD);

    // pc wraps from the top of the word space to zero
    i_read_sel = 0; ready_id = 1;
    jmp_condition_ex = 1; jmp_adr_ex = 30'h3FFF_FFFF;
    step();
    redir_settle();
    step();
    step();
    chk_head("t8_top", 30'h3FFF_FFFF);
    step();
    chk("t8_wrap_pc", pc_id, 0);
    chk("t8_wrap_inst", inst_id, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
